lavanderia_scheduler: RTL and testbench
=======================================

# lavanderia_scheduler

Shared-machine scheduler for the laundromat controller. It accepts paid service requests from NUM_REQ payment kiosks over a valid/ready handshake and arbitrates them round-robin onto one washer and one dryer. It then drives the SECADO / LAVADO / LAVADO_PESADO activation levels for the fixed per-service duration. It sits downstream of the per-kiosk coin FSMs and upstream of the machine drivers.

## Interface
- NUM_REQ, 2: number of requesting kiosks (2..8).
- DRY_CYCLES, 30: dryer active cycles for service 01 (≥1).
- WASH_CYCLES, 40: washer active cycles for service 10 (≥1).
- HEAVY_CYCLES, 90: washer active cycles for service 11 (≥ WASH_CYCLES).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  kiosk i holds a request.
- req_svc  in  2*NUM_REQ  service code of kiosk i in bits [2i+1:2i]: 00 none/insufficient, 01 dry, 10 wash, 11 heavy wash.
- req_ready  out  NUM_REQ  combinational grant, at most one bit set; transfer occurs at the edge where req_valid[i] & req_ready[i].
- req_reject  out  NUM_REQ  combinational, set for every i with req_valid[i] and code 00.
- secado  out  1  dryer active level.
- lavado  out  1  washer active, normal cycle.
- lavado_pesado  out  1  washer active, heavy cycle.
- done_dry, done_wash  out  1  one-cycle pulse during the last active cycle of the machine.
- served_count  out  8  count of accepted grants, wraps 255→0.

## Operation
- Each machine has a two-state FSM: IDLE → RUN on grant; RUN → IDLE when timer reaches 0.
- A machine is free only when its FSM is in IDLE.
- Timer width is $clog2(HEAVY_CYCLES+1). On grant the timer loads duration−1, then decrements once per RUN cycle.
- The active output is high for every RUN cycle. The done pulse is asserted when the timer is 0 in RUN.
- Kiosk i is eligible when all of the following hold: req_valid[i], code ≠ 00, and the target machine is free. Code 01 targets the dryer. Codes 10 and 11 target the washer.
- Grant selection:
  - Use a single round-robin pointer; at most one grant per cycle, even if both machines are free.
  - Grant the first eligible kiosk scanning from the pointer upward, with wrap.
  - After granting kiosk g, the pointer becomes (g+1) mod NUM_REQ.
  - The pointer is unchanged on cycles with no grant.
- req_svc is sampled only in the grant cycle. The kiosk drops req_valid after the transfer edge.
- Code 00 is never granted. req_reject stays asserted each cycle while the request is held, and it does not move the pointer.
- Ineligible valid requests wait. There is no timeout.
- On grant, served_count increments by 1 at the same edge.

## Timing
- Reset values: req_ready=0, req_reject=0, secado=0, lavado=0, lavado_pesado=0, done_dry=0, done_wash=0, served_count=0. Both FSMs IDLE, timers 0, pointer 0.
- While rst is high, req_ready and req_reject are forced to 0.
- Grant in cycle t → the output is high in cycles t+1 .. t+D, where D is the service duration. done_* is high in cycle t+D.
- Earliest regrant of the same machine is cycle t+D+1, so its next output starts at t+D+2. This guarantees a 1-cycle idle gap.
- A machine in its last RUN cycle is not free. A request arriving then is granted one cycle later.
- Both machines may run concurrently. Grants to different machines happen on different cycles.
- lavado and lavado_pesado are never high together.
- rst mid-run clears all outputs and timers at that edge. No done pulse is emitted for the aborted run.

## Test plan
Test parameters: NUM_REQ=2, DRY_CYCLES=3, WASH_CYCLES=4, HEAVY_CYCLES=9.
- **Single dry.** Kiosk0 requests 01 at cycle 2 → req_ready[0] is high in cycle 2, secado is high in cycles 3–5, done_dry is high in cycle 5, served_count=1.
- **Contention.** Both kiosks request 10 at cycle 2 with pointer 0 → kiosk0 is granted at cycle 2 and lavado is high in 3–6. Kiosk1 is granted at cycle 7 and lavado is high in 8–11.
- **Concurrency.** Kiosk0 requests 11 and kiosk1 requests 01 at cycle 2 → kiosk0 is granted at 2 with lavado_pesado high in 3–11. Kiosk1 is granted at 3 with secado high in 4–6. done_wash pulses at 11.
- **Reject.** Kiosk1 holds 00 for 3 cycles → req_reject[1] is high in all 3 cycles. There is no grant, served_count is unchanged, and the pointer is unchanged.
- **Reset mid-run.** Assert rst during cycle 5 of a heavy wash → lavado_pesado=0 from the next cycle, there is no done_wash, and served_count=0.
- **Wrap.** 256 back-to-back dry services → served_count wraps to 0.

Source files
------------

// File: rtl/lavanderia_scheduler_if.sv
// Kiosk-to-scheduler request bus: per-kiosk valid/service code in, grant/reject back.
interface lavanderia_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_svc;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_reject;

  modport master (output req_valid, output req_svc, input req_ready, input req_reject);
  modport slave  (input req_valid, input req_svc, output req_ready, output req_reject);
endinterface

// File: rtl/lavanderia_scheduler.sv
// Round-robin arbitration of paid kiosk requests onto one dryer and one washer,
// each driven by a two-state FSM with a down-counting duration timer.
module lavanderia_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int DRY_CYCLES   = 30,
  parameter int WASH_CYCLES  = 40,
  parameter int HEAVY_CYCLES = 90
) (
  input  logic                   clk,
  input  logic                   rst,
  lavanderia_scheduler_if.slave  req,
  output logic                   secado,
  output logic                   lavado,
  output logic                   lavado_pesado,
  output logic                   done_dry,
  output logic                   done_wash,
  output logic [7:0]             served_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(HEAVY_CYCLES + 1);

  localparam logic [1:0] SVC_NONE  = 2'b00;
  localparam logic [1:0] SVC_DRY   = 2'b01;
  localparam logic [1:0] SVC_HEAVY = 2'b11;

  localparam logic [TMR_W-1:0] DRY_LOAD   = TMR_W'(DRY_CYCLES - 1);
  localparam logic [TMR_W-1:0] WASH_LOAD  = TMR_W'(WASH_CYCLES - 1);
  localparam logic [TMR_W-1:0] HEAVY_LOAD = TMR_W'(HEAVY_CYCLES - 1);

  typedef enum logic {
    M_IDLE = 1'b0,
    M_RUN  = 1'b1
  } mach_state_t;

  mach_state_t        dry_state, dry_state_next;
  mach_state_t        wash_state, wash_state_next;
  logic [TMR_W-1:0]   dry_timer, dry_timer_next;
  logic [TMR_W-1:0]   wash_timer, wash_timer_next;
  logic               wash_heavy, wash_heavy_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [7:0]         count;

  logic               dry_free, wash_free;
  logic [NUM_REQ-1:0] eligible;
  logic [2*NUM_REQ-1:0] elig_dbl, elig_rot;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [1:0]         grant_svc;
  int                 scan_idx;

  assign dry_free  = (dry_state == M_IDLE);
  assign wash_free = (wash_state == M_IDLE);

  // Eligibility and rejection are purely combinational on the held request.
  always_comb begin
    eligible       = '0;
    req.req_reject = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req.req_valid[i] && (req.req_svc[2*i +: 2] != SVC_NONE)) begin
        eligible[i] = (req.req_svc[2*i +: 2] == SVC_DRY) ? dry_free : wash_free;
      end
      req.req_reject[i] = !rst && req.req_valid[i] && (req.req_svc[2*i +: 2] == SVC_NONE);
    end
  end

  // Rotate eligibility so bit 0 is the kiosk under the pointer, then take the first set bit.
  assign elig_dbl = {eligible, eligible};
  assign elig_rot = elig_dbl >> ptr;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_vld && elig_rot[k]) begin
          grant_vld = 1'b1;
          scan_idx  = int'(ptr) + k;
          if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
          grant_idx = PTR_W'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    grant_svc     = SVC_NONE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (grant_idx == PTR_W'(i))) begin
        req.req_ready[i] = 1'b1;
        grant_svc        = req.req_svc[2*i +: 2];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_vld) begin
      ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    dry_state_next = dry_state;
    dry_timer_next = dry_timer;
    case (dry_state)
      M_IDLE: begin
        if (grant_vld && (grant_svc == SVC_DRY)) begin
          dry_state_next = M_RUN;
          dry_timer_next = DRY_LOAD;
        end
      end
      M_RUN: begin
        if (dry_timer == '0) dry_state_next = M_IDLE;
        else                 dry_timer_next = dry_timer - 1'b1;
      end
      default: dry_state_next = M_IDLE;
    endcase
  end

  always_comb begin
    wash_state_next = wash_state;
    wash_timer_next = wash_timer;
    wash_heavy_next = wash_heavy;
    case (wash_state)
      M_IDLE: begin
        if (grant_vld && (grant_svc != SVC_DRY) && (grant_svc != SVC_NONE)) begin
          wash_state_next = M_RUN;
          wash_heavy_next = (grant_svc == SVC_HEAVY);
          wash_timer_next = (grant_svc == SVC_HEAVY) ? HEAVY_LOAD : WASH_LOAD;
        end
      end
      M_RUN: begin
        if (wash_timer == '0) wash_state_next = M_IDLE;
        else                  wash_timer_next = wash_timer - 1'b1;
      end
      default: wash_state_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dry_state  <= M_IDLE;
      wash_state <= M_IDLE;
      dry_timer  <= '0;
      wash_timer <= '0;
      wash_heavy <= 1'b0;
      ptr        <= '0;
      count      <= '0;
    end else begin
      dry_state  <= dry_state_next;
      wash_state <= wash_state_next;
      dry_timer  <= dry_timer_next;
      wash_timer <= wash_timer_next;
      wash_heavy <= wash_heavy_next;
      ptr        <= ptr_next;
      if (grant_vld) count <= count + 8'd1;
    end
  end

  assign secado        = (dry_state == M_RUN);
  assign lavado        = (wash_state == M_RUN) && !wash_heavy;
  assign lavado_pesado = (wash_state == M_RUN) && wash_heavy;
  assign done_dry      = (dry_state == M_RUN) && (dry_timer == '0);
  assign done_wash     = (wash_state == M_RUN) && (wash_timer == '0);
  assign served_count  = count;

endmodule

// File: tb/tb_lavanderia_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/rejects/done pulses, a negedge monitor pops and compares.
module tb_lavanderia_scheduler;

  localparam int NUM_REQ = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       secado, lavado, lavado_pesado, done_dry, done_wash;
  logic [7:0] served_count;

  int cyc = 0;
  int base = 0;
  int applied = 0;
  int miscomp = 0;
  int dry_len = 0;
  int wash_len = 0;

  typedef struct { int cyc; logic [1:0] mask; logic [7:0] cnt; } g_t;
  typedef struct { int cyc; logic [1:0] mask; } r_t;
  typedef struct { int cyc; int len; logic heavy; } d_t;

  g_t gq[$];
  r_t rq[$];
  d_t dq[$];
  d_t wq[$];

  lavanderia_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  lavanderia_scheduler #(
    .NUM_REQ(NUM_REQ), .DRY_CYCLES(3), .WASH_CYCLES(4), .HEAVY_CYCLES(9)
  ) dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .secado(secado), .lavado(lavado), .lavado_pesado(lavado_pesado),
    .done_dry(done_dry), .done_wash(done_wash), .served_count(served_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic report(input bit ok, input string name, input string got, input string want);
    applied++;
    if (!ok) begin
      miscomp++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  function automatic void push_g(input int c, input logic [1:0] m, input logic [7:0] n);
    gq.push_back('{cyc: c, mask: m, cnt: n});
  endfunction
  function automatic void push_r(input int c, input logic [1:0] m);
    rq.push_back('{cyc: c, mask: m});
  endfunction
  function automatic void push_d(input int c);
    dq.push_back('{cyc: c, len: 3, heavy: 1'b0});
  endfunction
  function automatic void push_w(input int c, input int l, input logic h);
    wq.push_back('{cyc: c, len: l, heavy: h});
  endfunction

  // Monitor: runs every falling edge, independent of the stimulus.
  always @(negedge clk) begin
    int rc;
    rc = cyc - base;
    if (secado === 1'b1) dry_len++; else dry_len = 0;
    if ((lavado === 1'b1) || (lavado_pesado === 1'b1)) wash_len++; else wash_len = 0;
    if ((lavado === 1'b1) && (lavado_pesado === 1'b1))
      report(1'b0, "wash_exclusive", $sformatf("both high rc=%0d", rc), "one level");
    if (bus.req_reject != '0) begin
      if (rq.size() == 0) report(1'b0, "reject_unexpected", $sformatf("mask=%b rc=%0d", bus.req_reject, rc), "none");
      else begin
        r_t e;
        e = rq.pop_front();
        report((e.cyc == rc) && (e.mask == bus.req_reject), "reject",
               $sformatf("rc=%0d mask=%b", rc, bus.req_reject), $sformatf("rc=%0d mask=%b", e.cyc, e.mask));
      end
    end
    if (bus.req_ready != '0) begin
      if (gq.size() == 0) report(1'b0, "grant_unexpected", $sformatf("mask=%b rc=%0d", bus.req_ready, rc), "none");
      else begin
        g_t e;
        e = gq.pop_front();
        report((e.cyc == rc) && (e.mask == bus.req_ready) && (e.cnt == served_count), "grant",
               $sformatf("rc=%0d ready=%b cnt=%0d", rc, bus.req_ready, served_count),
               $sformatf("rc=%0d ready=%b cnt=%0d", e.cyc, e.mask, e.cnt));
      end
    end
    if (done_dry === 1'b1) begin
      if (dq.size() == 0) report(1'b0, "done_dry_unexpected", $sformatf("rc=%0d", rc), "none");
      else begin
        d_t e;
        e = dq.pop_front();
        report((e.cyc == rc) && (e.len == dry_len), "done_dry",
               $sformatf("rc=%0d len=%0d", rc, dry_len), $sformatf("rc=%0d len=%0d", e.cyc, e.len));
      end
    end
    if (done_wash === 1'b1) begin
      if (wq.size() == 0) report(1'b0, "done_wash_unexpected", $sformatf("rc=%0d", rc), "none");
      else begin
        d_t e;
        e = wq.pop_front();
        report((e.cyc == rc) && (e.len == wash_len) && (e.heavy == lavado_pesado), "done_wash",
               $sformatf("rc=%0d len=%0d heavy=%b", rc, wash_len, lavado_pesado),
               $sformatf("rc=%0d len=%0d heavy=%b", e.cyc, e.len, e.heavy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int rc);
    while (cyc < base + rc) tick();
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] s);
    bus.req_valid = v;
    bus.req_svc   = s;
  endtask

  task automatic check_count(input string name, input logic [7:0] want);
    report(served_count == want, name, $sformatf("%0d", served_count), $sformatf("%0d", want));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    report({secado, lavado, lavado_pesado, done_dry, done_wash, served_count, bus.req_ready, bus.req_reject} == '0,
           "reset_state",
           $sformatf("sec=%b lav=%b pes=%b dd=%b dw=%b cnt=%0d rdy=%b rej=%b", secado, lavado, lavado_pesado,
                     done_dry, done_wash, served_count, bus.req_ready, bus.req_reject),
           "all zero");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
    $fatal(1);
  end

  initial begin
    drive(2'b00, 4'b0000);

    // Single dry on kiosk 0.
    do_reset();
    push_g(2, 2'b01, 8'd0); push_d(5);
    goto(2); drive(2'b01, 4'b0001);
    goto(3); drive(2'b00, 4'b0000);
    goto(8); check_count("single_dry_count", 8'd1);

    // Contention: both kiosks want a normal wash.
    do_reset();
    push_g(2, 2'b01, 8'd0); push_w(6, 4, 1'b0);
    push_g(7, 2'b10, 8'd1); push_w(11, 4, 1'b0);
    goto(2); drive(2'b11, 4'b1010);
    goto(3); drive(2'b10, 4'b1010);
    goto(8); drive(2'b00, 4'b0000);
    goto(14); check_count("contention_count", 8'd2);

    // Concurrency: heavy wash on kiosk 0, dry on kiosk 1.
    do_reset();
    push_g(2, 2'b01, 8'd0); push_w(11, 9, 1'b1);
    push_g(3, 2'b10, 8'd1); push_d(6);
    goto(2); drive(2'b11, 4'b0111);
    goto(3); drive(2'b10, 4'b0111);
    goto(4); drive(2'b00, 4'b0000);
    goto(14); check_count("concurrency_count", 8'd2);

    // Reject holds neither count nor pointer; pointer sits at 1 beforehand.
    do_reset();
    push_g(2, 2'b01, 8'd0); push_d(5);
    push_r(6, 2'b10); push_r(7, 2'b10); push_r(8, 2'b10);
    push_g(10, 2'b10, 8'd1); push_d(13);
    push_g(14, 2'b01, 8'd2); push_d(17);
    goto(2); drive(2'b01, 4'b0001);
    goto(3); drive(2'b00, 4'b0000);
    goto(6); drive(2'b10, 4'b0000);
    goto(9); drive(2'b00, 4'b0000);
    check_count("reject_count", 8'd1);
    goto(10); drive(2'b11, 4'b0101);
    goto(11); drive(2'b01, 4'b0101);
    goto(15); drive(2'b00, 4'b0000);
    goto(20); check_count("reject_after_count", 8'd3);

    // Reset in the fifth cycle of a heavy wash, with requests held during reset.
    do_reset();
    push_g(2, 2'b01, 8'd0);
    goto(2); drive(2'b01, 4'b0011);
    goto(3); drive(2'b00, 4'b0000);
    goto(7);
    report(lavado_pesado === 1'b1, "heavy_running", $sformatf("%b", lavado_pesado), "1");
    rst = 1'b1; drive(2'b11, 4'b0100);
    goto(8);
    report((lavado_pesado === 1'b0) && (served_count == 8'd0), "reset_midrun",
           $sformatf("pes=%b cnt=%0d", lavado_pesado, served_count), "pes=0 cnt=0");
    drive(2'b00, 4'b0000);
    goto(9); rst = 1'b0;
    goto(14);

    // 256 back-to-back dry services wrap the counter.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      push_g(2 + 4*n, 2'b01, 8'(n));
      push_d(5 + 4*n);
    end
    goto(2); drive(2'b01, 4'b0001);
    goto(1023); drive(2'b00, 4'b0000);
    check_count("wrap_count", 8'd0);
    goto(1030);

    report(gq.size() == 0, "grant_queue_drained", $sformatf("%0d left", gq.size()), "0 left");
    report(rq.size() == 0, "reject_queue_drained", $sformatf("%0d left", rq.size()), "0 left");
    report(dq.size() == 0, "dry_queue_drained", $sformatf("%0d left", dq.size()), "0 left");
    report(wq.size() == 0, "wash_queue_drained", $sformatf("%0d left", wq.size()), "0 left");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
    $finish;
  end

endmodule
